// File: rtl/srmem_pingpong.sv
// ---------------------------------------------------------------------------
// srmem_pingpong
//   Double-buffered shift-register memory. The design has two banks. Each
//   bank has NUM_RDPORT lanes of LEN_SRMEM entries, and each entry is
//   {valid, data}.
//   - Write side: it fills one bank round-robin across the lanes.
//   - Read side: it pops whole head rows from the other bank.
//   - A partially filled bank is padded and then shifted (MOVING) until its
//     data sits at the head. Only then is the bank exposed to the reader.
//
// Optional feature macro: SRMEM_EARLY_END_EN
//   defined   : a read ends after the last real row of the bank
//   undefined : all LEN_SRMEM rows are popped
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   valid_din    write strobe (ignored while wrfull)
//   din          write payload
//   is_lastdin   closes the write bank after this entry
//   wrfull       write bank is MOVING or FULL
//   wrend        pulse: write bank closed this cycle
//   req_pop      pop head row of the read bank
//   rdvalid      read bank is FULL; rd_data valid
//   rd_data      head row, lane k at [k*(DATA_BW+1) +: DATA_BW+1]
//   rdlast       accepted pop is the final row of the bank
//   rd_bank      index of the bank being read
// ---------------------------------------------------------------------------
module srmem_pingpong #(
    parameter int NUM_RDPORT = 4,
    parameter int LEN_SRMEM  = 8,
    parameter int DATA_BW    = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                valid_din,
    input  logic [DATA_BW-1:0]                  din,
    input  logic                                is_lastdin,
    output logic                                wrfull,
    output logic                                wrend,
    input  logic                                req_pop,
    output logic                                rdvalid,
    output logic [NUM_RDPORT*(DATA_BW+1)-1:0]   rd_data,
    output logic                                rdlast,
    output logic                                rd_bank
);

    localparam int EW = DATA_BW + 1;
    localparam int RW = $clog2(LEN_SRMEM + 1);
    localparam int PW = (NUM_RDPORT > 1) ? $clog2(NUM_RDPORT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_FILLING = 2'b01,
        ST_MOVING  = 2'b10,
        ST_FULL    = 2'b11
    } bank_st_e;

    bank_st_e        st_q    [2];
    bank_st_e        st_d    [2];
    logic [RW-1:0]   rows_q  [2];
    logic [RW-1:0]   rows_d  [2];
    logic [RW-1:0]   mvcnt_q [2];
    logic [RW-1:0]   mvcnt_d [2];
    logic [PW-1:0]   memptr_q, memptr_d;
    logic [RW-1:0]   rdcnt_q, rdcnt_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [EW-1:0]   mem_q [2][NUM_RDPORT][LEN_SRMEM];
    logic [EW-1:0]   mem_d [2][NUM_RDPORT][LEN_SRMEM];

    logic            sh_en [2][NUM_RDPORT];
    logic [EW-1:0]   sh_in [2][NUM_RDPORT];

    logic            wr_ok, wr_close, do_pop;
    logic [RW-1:0]   rows_new, rd_end;

    assign wrfull  = (st_q[wr_bank_q] == ST_MOVING) || (st_q[wr_bank_q] == ST_FULL);
    assign rdvalid = (st_q[rd_bank_q] == ST_FULL);
    assign rd_bank = rd_bank_q;
    assign do_pop  = req_pop && rdvalid;

`ifdef SRMEM_EARLY_END_EN
    assign rd_end = rows_q[rd_bank_q];
`else
    assign rd_end = RW'(LEN_SRMEM);
`endif

    assign rdlast   = do_pop && (rdcnt_q == rd_end - RW'(1));
    assign wr_ok    = valid_din && !wrfull;
    // A new row starts whenever lane 0 is written.
    assign rows_new = rows_q[wr_bank_q] + RW'(memptr_q == '0);
    assign wr_close = wr_ok && (is_lastdin ||
                      ((rows_new == RW'(LEN_SRMEM)) && (memptr_q == PW'(NUM_RDPORT - 1))));
    assign wrend    = wr_close;

    always_comb begin
        for (int k = 0; k < NUM_RDPORT; k++) begin
            rd_data[k*EW +: EW] = rdvalid ? mem_q[rd_bank_q][k][0] : '0;
        end
    end

    always_comb begin
        st_d      = st_q;
        rows_d    = rows_q;
        mvcnt_d   = mvcnt_q;
        memptr_d  = memptr_q;
        rdcnt_d   = rdcnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        mem_d     = mem_q;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < NUM_RDPORT; k++) begin
                sh_en[b][k] = 1'b0;
                sh_in[b][k] = '0;
            end
        end

        if (wr_ok) begin
            // The addressed lane takes the data. On close, the lanes after it
            // take padding, so every lane ends up holding `rows` entries.
            for (int k = 0; k < NUM_RDPORT; k++) begin
                if (PW'(k) == memptr_q) begin
                    sh_en[wr_bank_q][k] = 1'b1;
                    sh_in[wr_bank_q][k] = {1'b1, din};
                end else if (wr_close && (PW'(k) > memptr_q)) begin
                    sh_en[wr_bank_q][k] = 1'b1;
                end
            end
            rows_d[wr_bank_q] = rows_new;
            if (wr_close) begin
                memptr_d  = '0;
                wr_bank_d = ~wr_bank_q;
                if (rows_new == RW'(LEN_SRMEM)) begin
                    st_d[wr_bank_q] = ST_FULL;
                end else begin
                    st_d[wr_bank_q]    = ST_MOVING;
                    mvcnt_d[wr_bank_q] = rows_new;
                end
            end else begin
                memptr_d        = (memptr_q == PW'(NUM_RDPORT - 1)) ? '0 : memptr_q + PW'(1);
                st_d[wr_bank_q] = ST_FILLING;
            end
        end

        // MOVING pushes the data toward the head until the bank has seen
        // LEN_SRMEM shifts in total.
        for (int b = 0; b < 2; b++) begin
            if (st_q[b] == ST_MOVING) begin
                for (int k = 0; k < NUM_RDPORT; k++) sh_en[b][k] = 1'b1;
                mvcnt_d[b] = mvcnt_q[b] + RW'(1);
                if (mvcnt_q[b] + RW'(1) == RW'(LEN_SRMEM)) st_d[b] = ST_FULL;
            end
        end

        if (do_pop) begin
            for (int k = 0; k < NUM_RDPORT; k++) sh_en[rd_bank_q][k] = 1'b1;
            rdcnt_d = rdcnt_q + RW'(1);
        end

        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < NUM_RDPORT; k++) begin
                if (sh_en[b][k]) begin
                    for (int i = 0; i < LEN_SRMEM - 1; i++) mem_d[b][k][i] = mem_q[b][k][i+1];
                    mem_d[b][k][LEN_SRMEM-1] = sh_in[b][k];
                end
            end
        end

        // With early end the padded tail may still be in the bank, so clear it.
        if (rdlast) begin
            st_d[rd_bank_q]    = ST_IDLE;
            rows_d[rd_bank_q]  = '0;
            mvcnt_d[rd_bank_q] = '0;
            rdcnt_d            = '0;
            rd_bank_d          = ~rd_bank_q;
            for (int k = 0; k < NUM_RDPORT; k++) begin
                for (int i = 0; i < LEN_SRMEM; i++) mem_d[rd_bank_q][k][i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                st_q[b]    <= ST_IDLE;
                rows_q[b]  <= '0;
                mvcnt_q[b] <= '0;
                for (int k = 0; k < NUM_RDPORT; k++) begin
                    for (int i = 0; i < LEN_SRMEM; i++) mem_q[b][k][i] <= '0;
                end
            end
            memptr_q  <= '0;
            rdcnt_q   <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            rows_q    <= rows_d;
            mvcnt_q   <= mvcnt_d;
            mem_q     <= mem_d;
            memptr_q  <= memptr_d;
            rdcnt_q   <= rdcnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

endmodule
